bmem_line_adapter: RTL and testbench
====================================

// Module: bmem_line_adapter
// PURPOSE
//  CPU-side initiator for the banked burst memory interface (bmem_*). Accepts whole-cache-line
//  read/write requests from the I-cache (read-only) and D-cache, arbitrates (D over I), and
//  converts each into one 4-beat 64-bit burst on bmem. Reassembles read beats by matching
//  bmem_raddr. Sits between the cache pair and the cpu's bmem_* top-level ports.
// PARAMETERS
//  ADDR_W  32               byte address width
//  BEAT_W  64               bmem data beat width
//  BEATS   4                beats per line; line = BEAT_W*BEATS = 256 bits, aligned to 32 B
// PORTS
//  clk           in   1        clock, all logic on posedge
//  rst           in   1        synchronous, active-low reset (0 = reset)
//  i_req_addr    in   ADDR_W   I-cache line address (low 5 bits ignored)
//  i_req_read    in   1        I-cache read request, level, held until i_resp_valid
//  i_resp_valid  out  1        1-cycle pulse: i_resp_rdata valid
//  i_resp_rdata  out  256      line data, beat0 in [63:0]
//  d_req_addr    in   ADDR_W   D-cache line address (low 5 bits ignored)
//  d_req_read    in   1        D-cache read request, level
//  d_req_write   in   1        D-cache writeback request, level
//  d_req_wdata   in   256      writeback line, sampled at grant
//  d_resp_valid  out  1        1-cycle pulse: read data valid or write complete
//  d_resp_rdata  out  256      line data
//  bmem_addr     out  ADDR_W   burst address (aligned, low 5 bits 0)
//  bmem_read     out  1        read burst request, accepted when bmem_ready=1
//  bmem_write    out  1        write beat valid, accepted when bmem_ready=1
//  bmem_wdata    out  BEAT_W   write beat
//  bmem_ready    in   1        memory accepts read request / write beat this cycle
//  bmem_raddr    in   ADDR_W   address tag of returning read beat
//  bmem_rdata    in   BEAT_W   returning read beat
//  bmem_rvalid   in   1        read beat valid
//  err_raddr     out  1        sticky: rvalid beat in RD_WAIT with raddr != outstanding addr
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE, beat_cnt 0, owner I, all outputs 0, err_raddr 0.
//   Reset mid-burst abandons the transaction; no resp pulse is issued.
//  States: IDLE, RD_ISSUE, RD_WAIT, WR_BEAT, RESP. One transaction in flight.
//  IDLE: D request wins over I. d_req_write beats d_req_read if both (illegal; assertion fires).
//   On grant latch owner, addr & ~31, wdata; beat_cnt<=0; go RD_ISSUE or WR_BEAT.
//  RD_ISSUE: bmem_read=1, bmem_addr=latched; on bmem_ready -> RD_WAIT (one request only).
//  RD_WAIT: bmem_rvalid && bmem_raddr==latched addr -> line[beat_cnt*64 +: 64]<=rdata,
//   beat_cnt++; 4th beat -> RESP. Mismatched raddr: beat dropped, err_raddr<=1.
//   rvalid in any other state is ignored; err_raddr unchanged.
//  WR_BEAT: bmem_write=1, bmem_addr=latched, bmem_wdata=wdata[beat_cnt*64 +: 64];
//   beat_cnt++ only when bmem_ready; 4th accepted beat -> RESP. ready=0 holds beat.
//  RESP: owner's resp_valid=1 for exactly one cycle (rdata = assembled line; for writes,
//   d_resp_rdata undefined), -> IDLE. Clients drop req the cycle after resp_valid.
//  bmem_read/bmem_write never both 1; both 0 outside RD_ISSUE/WR_BEAT.
//  Latency: write with ready=1: grant cycle, 4 WR cycles, resp 5 cycles after grant.
//   Read: resp 1 cycle after the cycle carrying the 4th matching beat.
//  beat_cnt is 2 bits; wraps to 0 at RESP. resp_rdata holds until next read completes.
// TESTING
//  Reset: rst=0 2 cycles with d_req_read=1 -> no bmem_read, resp_valid 0, err 0.
//  D read addr 0x1234_5678, mem returns 4 beats raddr 0x1234_5660 data 0xA0..A3 ->
//   bmem_addr 0x1234_5660, d_resp_valid once, d_resp_rdata {A3,A2,A1,A0}.
//  D write 0x0000_1000 line {D3..D0}, ready low on 2nd beat for 3 cycles ->
//   wdata D0,D1(held 3 cyc+1),D2,D3 in order; d_resp_valid 1 cycle after D3 accepted.
//  I and D read same cycle -> D served first; I burst issued only after d_resp_valid.
//  RD_WAIT beat with raddr 0x2000 vs 0x1000 -> dropped, err_raddr=1, 4 correct beats done.
//  rst=0 in RD_WAIT after 2 beats -> IDLE, no resp; stale beats ignored, err_raddr 0.

Source files
------------

// File: rtl/bmem_line_adapter_if.sv
// Purpose : bmem burst bus between the line adapter (master) and banked memory (slave).
// Latency : n/a (signal bundle only).
// Backpressure: bmem_ready gates read requests and write beats; read beats are not throttled.
//
// Signals
//   bmem_addr   line-aligned burst address
//   bmem_read   read burst request, accepted when bmem_ready=1
//   bmem_write  write beat valid, accepted when bmem_ready=1
//   bmem_wdata  write beat
//   bmem_ready  memory accepts the request / beat this cycle
//   bmem_raddr  address tag of a returning read beat
//   bmem_rdata  returning read beat
//   bmem_rvalid returning read beat valid
interface bmem_line_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64
);
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_line_adapter.sv
// Purpose : turns I/D cache line requests (D has priority) into single 4-beat bmem bursts.
// Latency : write with ready=1 responds 5 cycles after grant; read responds 1 cycle after 4th tagged beat.
// Backpressure: bmem_ready=0 holds the read request or the current write beat; one transaction in flight.
//
// Ports
//   clk, rst            clock and synchronous active-low reset (0 = reset)
//   i_req_* / i_resp_*  I-cache read-only line port, level request, 1-cycle response pulse
//   d_req_* / d_resp_*  D-cache read/writeback line port, level request, 1-cycle response pulse
//   bmem                burst memory bus (master side)
//   err_raddr           sticky flag: read beat arrived with a tag not matching the outstanding burst
module bmem_line_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_W-1:0]        i_req_addr,
    input  logic                     i_req_read,
    output logic                     i_resp_valid,
    output logic [BEAT_W*BEATS-1:0]  i_resp_rdata,

    input  logic [ADDR_W-1:0]        d_req_addr,
    input  logic                     d_req_read,
    input  logic                     d_req_write,
    input  logic [BEAT_W*BEATS-1:0]  d_req_wdata,
    output logic                     d_resp_valid,
    output logic [BEAT_W*BEATS-1:0]  d_resp_rdata,

    bmem_line_adapter_if.master      bmem,

    output logic                     err_raddr
);
    localparam int LINE_W     = BEAT_W * BEATS;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int CNT_W      = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_BEAT,
        S_RESP
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                owner_q,    owner_d;     // 0 = I-cache, 1 = D-cache
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [LINE_W-1:0]   wdata_q,    wdata_d;
    logic [LINE_W-1:0]   line_q,     line_d;
    logic                err_q,      err_d;

    int                  beat_lsb;

    always_comb begin
        beat_lsb = int'(beat_cnt_q) * BEAT_W;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            line_q     <= line_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        line_d     = line_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                // D-cache wins; within D a writeback wins over a read.
                if (d_req_write || d_req_read) begin
                    owner_d    = 1'b1;
                    addr_d     = d_req_addr & ALIGN_MASK;
                    beat_cnt_d = '0;
                    if (d_req_write) begin
                        wdata_d = d_req_wdata;
                        state_d = S_WR_BEAT;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end else if (i_req_read) begin
                    owner_d    = 1'b0;
                    addr_d     = i_req_addr & ALIGN_MASK;
                    beat_cnt_d = '0;
                    state_d    = S_RD_ISSUE;
                end
            end

            S_RD_ISSUE: begin
                if (bmem.bmem_ready) begin
                    state_d = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                // Only beats tagged with our burst address are ours; anything else is
                // a protocol error on the memory side and is dropped.
                if (bmem.bmem_rvalid) begin
                    if (bmem.bmem_raddr == addr_q) begin
                        line_d[beat_lsb +: BEAT_W] = bmem.bmem_rdata;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_d = S_RESP;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_WR_BEAT: begin
                if (bmem.bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; address and data are forced to 0 when idle.
    always_comb begin
        bmem.bmem_read  = 1'b0;
        bmem.bmem_write = 1'b0;
        bmem.bmem_addr  = '0;
        bmem.bmem_wdata = '0;
        i_resp_valid    = 1'b0;
        d_resp_valid    = 1'b0;

        case (state_q)
            S_RD_ISSUE: begin
                bmem.bmem_read = 1'b1;
                bmem.bmem_addr = addr_q;
            end
            S_WR_BEAT: begin
                bmem.bmem_write = 1'b1;
                bmem.bmem_addr  = addr_q;
                bmem.bmem_wdata = wdata_q[beat_lsb +: BEAT_W];
            end
            S_RESP: begin
                if (owner_q) begin
                    d_resp_valid = 1'b1;
                end else begin
                    i_resp_valid = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // The assembled line stays visible until the next read overwrites it.
    assign i_resp_rdata = line_q;
    assign d_resp_rdata = line_q;
    assign err_raddr    = err_q;

    a_d_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == S_IDLE && d_req_read && d_req_write));

    a_bmem_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bmem.bmem_read && bmem.bmem_write));
endmodule

// File: tb/tb_bmem_line_adapter.sv
module tb_bmem_line_adapter;
    localparam int AW = 32;
    localparam int BW = 64;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_req_read = 1'b0;
    logic          i_resp_valid;
    logic [LW-1:0] i_resp_rdata;
    logic [AW-1:0] d_req_addr = '0;
    logic          d_req_read = 1'b0;
    logic          d_req_write = 1'b0;
    logic [LW-1:0] d_req_wdata = '0;
    logic          d_resp_valid;
    logic [LW-1:0] d_resp_rdata;
    logic          err_raddr;

    bmem_line_adapter_if #(.ADDR_W(AW), .BEAT_W(BW)) bus ();

    bmem_line_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_addr   (i_req_addr),
        .i_req_read   (i_req_read),
        .i_resp_valid (i_resp_valid),
        .i_resp_rdata (i_resp_rdata),
        .d_req_addr   (d_req_addr),
        .d_req_read   (d_req_read),
        .d_req_write  (d_req_write),
        .d_req_wdata  (d_req_wdata),
        .d_resp_valid (d_resp_valid),
        .d_resp_rdata (d_resp_rdata),
        .bmem         (bus.master),
        .err_raddr    (err_raddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } bev_t;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [LW-1:0] data;
    } rev_t;

    bev_t bq[$];
    rev_t rq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bmem_read(input string name);
        int n = 0;
        while (bus.bmem_read !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, LW'(bus.bmem_read), LW'(1));
    endtask

    task automatic wait_bmem_write(input string name);
        int n = 0;
        while (bus.bmem_write !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, LW'(bus.bmem_write), LW'(1));
    endtask

    task automatic wait_resp(input logic is_d, input string name);
        int n = 0;
        while ((is_d ? d_resp_valid : i_resp_valid) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, LW'(is_d ? d_resp_valid : i_resp_valid), LW'(1));
    endtask

    task automatic give_beat(input logic [AW-1:0] ra, input logic [BW-1:0] d);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = ra;
        bus.bmem_rdata  = d;
        step();
        bus.bmem_rvalid = 1'b0;
    endtask

    // Monitor: compares every accepted bmem request/beat and every response pulse
    // against the scoreboard queues filled by the stimulus.
    initial begin : monitor
        bev_t be;
        rev_t re;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                chk("bmem_rw_excl", LW'(bus.bmem_read & bus.bmem_write), LW'(0));
                if ((bus.bmem_read === 1'b1 || bus.bmem_write === 1'b1) && bus.bmem_ready === 1'b1) begin
                    if (bq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL bmem_unexpected: got rd=%b wr=%b addr=%h want no request",
                                 bus.bmem_read, bus.bmem_write, bus.bmem_addr);
                    end else begin
                        be = bq.pop_front();
                        chk("bmem_kind", LW'(bus.bmem_write), LW'(be.wr));
                        chk("bmem_addr", LW'(bus.bmem_addr), LW'(be.addr));
                        if (be.wr) chk("bmem_wdata", LW'(bus.bmem_wdata), LW'(be.data));
                    end
                end
                if (i_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
                    if (rq.size() == 0 || (i_resp_valid === 1'b1 && d_resp_valid === 1'b1)) begin
                        total++;
                        bad++;
                        $display("FAIL resp_unexpected: got i=%b d=%b want no response",
                                 i_resp_valid, d_resp_valid);
                    end else begin
                        re = rq.pop_front();
                        chk("resp_owner", LW'(d_resp_valid), LW'(re.is_d));
                        if (!re.wr) chk("resp_data", re.is_d ? d_resp_rdata : i_resp_rdata, re.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [LW-1:0] line_a;
        logic [LW-1:0] line_w;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;

        // Reset held with a pending D read: nothing must be issued.
        rst        = 1'b0;
        d_req_read = 1'b1;
        d_req_addr = 32'h1234_5678;
        bus.bmem_ready = 1'b1;
        step();
        chk("rst_bmem_read", LW'(bus.bmem_read), LW'(0));
        chk("rst_d_resp", LW'(d_resp_valid), LW'(0));
        chk("rst_err", LW'(err_raddr), LW'(0));
        chk("rst_rdata", i_resp_rdata, LW'(0));
        step();
        chk("rst2_bmem_read", LW'(bus.bmem_read), LW'(0));
        chk("rst2_bmem_write", LW'(bus.bmem_write), LW'(0));
        d_req_read = 1'b0;
        rst = 1'b1;
        step();
        chk("idle_no_read", LW'(bus.bmem_read), LW'(0));

        // D read, unaligned address.
        line_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        bq.push_back('{1'b0, 32'h1234_5660, 64'h0});
        rq.push_back('{1'b1, 1'b0, line_a});
        d_req_addr = 32'h1234_5678;
        d_req_read = 1'b1;
        wait_bmem_read("t2_issue");
        chk("t2_addr", LW'(bus.bmem_addr), LW'(32'h1234_5660));
        step();
        chk("t2_one_req", LW'(bus.bmem_read), LW'(0));
        for (int i = 0; i < 4; i++) give_beat(32'h1234_5660, 64'hA0 + 64'(i));
        wait_resp(1'b1, "t2_resp");
        d_req_read = 1'b0;
        step();
        chk("t2_pulse", LW'(d_resp_valid), LW'(0));

        // D writeback with ready low on the second beat for 3 cycles.
        line_w = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        for (int i = 0; i < 4; i++) bq.push_back('{1'b1, 32'h0000_1000, 64'hD0 + 64'(i)});
        rq.push_back('{1'b1, 1'b1, '0});
        d_req_addr  = 32'h0000_1000;
        d_req_wdata = line_w;
        d_req_write = 1'b1;
        wait_bmem_write("t3_issue");
        chk("t3_beat0", LW'(bus.bmem_wdata), LW'(64'hD0));
        step();
        bus.bmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_vld", LW'(bus.bmem_write), LW'(1));
            chk("t3_hold_dat", LW'(bus.bmem_wdata), LW'(64'hD1));
            step();
        end
        bus.bmem_ready = 1'b1;
        step();
        step();
        step();
        chk("t3_resp_lat", LW'(d_resp_valid), LW'(1));
        d_req_write = 1'b0;
        step();
        chk("t3_rdata_hold", d_resp_rdata, line_a);

        // I and D read together: D first, I only after D responds.
        bq.push_back('{1'b0, 32'h0000_3000, 64'h0});
        bq.push_back('{1'b0, 32'h0000_2040, 64'h0});
        rq.push_back('{1'b1, 1'b0, {64'hB3, 64'hB2, 64'hB1, 64'hB0}});
        rq.push_back('{1'b0, 1'b0, {64'hC3, 64'hC2, 64'hC1, 64'hC0}});
        i_req_addr = 32'h0000_2040;
        i_req_read = 1'b1;
        d_req_addr = 32'h0000_3000;
        d_req_read = 1'b1;
        wait_bmem_read("t4_d_issue");
        chk("t4_d_first", LW'(bus.bmem_addr), LW'(32'h0000_3000));
        step();
        for (int i = 0; i < 4; i++) give_beat(32'h0000_3000, 64'hB0 + 64'(i));
        wait_resp(1'b1, "t4_d_resp");
        d_req_read = 1'b0;
        step();
        chk("t4_i_not_yet", LW'(bus.bmem_read), LW'(0));
        wait_bmem_read("t4_i_issue");
        chk("t4_i_addr", LW'(bus.bmem_addr), LW'(32'h0000_2040));
        step();
        for (int i = 0; i < 4; i++) give_beat(32'h0000_2040, 64'hC0 + 64'(i));
        wait_resp(1'b0, "t4_i_resp");
        i_req_read = 1'b0;
        step();

        // Mismatched read tag: dropped, sticky error, burst still completes.
        chk("t5_err_clear", LW'(err_raddr), LW'(0));
        bq.push_back('{1'b0, 32'h0000_1000, 64'h0});
        rq.push_back('{1'b1, 1'b0, {64'hE3, 64'hE2, 64'hE1, 64'hE0}});
        d_req_addr = 32'h0000_1000;
        d_req_read = 1'b1;
        wait_bmem_read("t5_issue");
        step();
        give_beat(32'h0000_2000, 64'hEE);
        chk("t5_err_set", LW'(err_raddr), LW'(1));
        for (int i = 0; i < 4; i++) give_beat(32'h0000_1000, 64'hE0 + 64'(i));
        wait_resp(1'b1, "t5_resp");
        chk("t5_err_sticky", LW'(err_raddr), LW'(1));
        d_req_read = 1'b0;
        step();

        // Reset in the middle of a read burst: abandoned, no response, stale beats ignored.
        bq.push_back('{1'b0, 32'h0000_4000, 64'h0});
        d_req_addr = 32'h0000_4000;
        d_req_read = 1'b1;
        wait_bmem_read("t6_issue");
        step();
        give_beat(32'h0000_4000, 64'hF0);
        give_beat(32'h0000_4000, 64'hF1);
        rst = 1'b0;
        d_req_read = 1'b0;
        step();
        chk("t6_rst_err", LW'(err_raddr), LW'(0));
        chk("t6_rst_rdata", d_resp_rdata, LW'(0));
        rst = 1'b1;
        give_beat(32'h0000_4000, 64'hF2);
        give_beat(32'h0000_4000, 64'hF3);
        step();
        step();
        chk("t6_no_resp", LW'(d_resp_valid), LW'(0));
        chk("t6_err_clear", LW'(err_raddr), LW'(0));
        chk("t6_idle", LW'(bus.bmem_read), LW'(0));

        chk("bq_empty", LW'(bq.size()), LW'(0));
        chk("rq_empty", LW'(rq.size()), LW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
